data_cache_ctrl: RTL and testbench
==================================

# data_cache_ctrl

Direct-mapped, write-through, no-write-allocate data cache between the memory-access stage and `data_memory`. Holds 2^SET_SIZE one-word `CacheBlock` entries (valid, 32-bit data, tag), answers read hits combinationally, and stalls the pipeline through a small FSM while it services read misses and write-throughs over a request/acknowledge memory port. Load sign/zero extension stays in the downstream load-extend logic: the block always returns the full aligned word.

## Interface
- `DATA_WIDTH`, 32, word width.
- `SET_SIZE`, 10, index bits; tag width = DATA_WIDTH-SET_SIZE-2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on `clk`.
- `cpu_req`  in  1  access valid this cycle.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address.
- `cpu_size`  in  2  `byte_format`: Word=00, HalfWord=01, Byte=10; 11 treated as Word.
- `cpu_wdata`  in  32  store data, right-justified.
- `cpu_rdata`  out  32  aligned word for loads.
- `cpu_stall`  out  1  hold the pipeline.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  read word, valid only while `mem_ack`=1.
- `mem_ack`  in  1  single-cycle completion pulse.

## Operation
- Address split: index = `addr[SET_SIZE+1:2]`, tag = `addr[31:SET_SIZE+2]`; hit = V && tag match.
- Lanes: Byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}; HalfWord: be = 0011<<{addr[1],0}, wdata = {2{wdata[15:0]}}; Word: be = 1111. `addr[0]` for HalfWord and `addr[1:0]` for Word are ignored; misalignment is not trapped.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, no `cpu_req`: stall 0, no change.
- IDLE, load hit: `cpu_rdata` = entry data, stall 0, stay IDLE.
- IDLE, load miss: stall 1; latch addr; next state RD_MISS.
- IDLE, store (hit or miss): stall 1; latch addr/be/wdata; next state WR_THRU.
- RD_MISS: `mem_req`=1, `mem_we`=0. On `mem_ack`: write entry {V=1, mem_rdata, tag}, `cpu_rdata`=`mem_rdata` (bypass), stall 0, next IDLE.
- WR_THRU: `mem_req`=1, `mem_we`=1, be/wdata from latch. On `mem_ack`: if latched index/tag hits, merge enabled bytes into the entry; on miss the cache is untouched; stall 0; next IDLE.
- Reset (`rst`=0 at edge): all V cleared in one cycle, state IDLE, latches 0. Reset mid-miss/write abandons the transaction; no fill or merge.

## Timing
- While `rst`=0: `cpu_stall`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0.
- Load hit: 0 extra cycles (combinational from `cpu_addr`).
- Miss/store: request seen in cycle 0; `mem_req` high from cycle 1 through the `mem_ack` cycle inclusive; address/be/wdata stable throughout. Stall covers cycles 0..N-1 where N = ack cycle; the CPU advances on the edge ending cycle N. Minimum latency is 1 stall cycle (ack in cycle 1).
- `mem_req` drops the cycle after ack; back-to-back request may be seen in IDLE that same cycle.
- `mem_ack` outside RD_MISS/WR_THRU is ignored.
- `cpu_*` inputs are ignored outside IDLE (the held pipeline keeps them stable).

## Test plan
- Reset, then load 0x0000_0040 with mem returning 0xDEADBEEF after 3 cycles -> `mem_req` cycles 1-3, `mem_addr`=0x40, `cpu_rdata`=0xDEADBEEF in ack cycle; repeat load -> hit, stall 0, same data, no `mem_req`.
- Conflict: load 0x40 then 0x1040 (same index, tag differs) -> second misses and refills; reload 0x40 misses again.
- Store Byte 0xAB to 0x41 after the 0x40 fill -> `mem_be`=0010, `mem_wdata`=0xABABABAB, `mem_we`=1; subsequent load 0x40 hits returning 0xDEADABEF.
- Store HalfWord 0x1234 to 0x2002 (uncached) -> `mem_be`=1100, `mem_wdata`=0x12341234; load 0x2002 then misses (no allocate).
- Assert `rst`=0 during RD_MISS before ack -> `mem_req` low after edge, stall 0; load to same address after release misses again.
- Ack in cycle 1 on a miss -> exactly one stall cycle; immediate back-to-back hit in the next cycle with stall 0.

Source files
------------

// File: rtl/data_cache_ctrl.sv
`timescale 1ns/1ps
// data_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// One-word blocks; read hits are answered combinationally, read misses and
// all stores stall the pipeline while a single request/ack memory transaction
// completes. The full aligned word is always returned on loads.
module data_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_SIZE   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [1:0]            cpu_size,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int TAG_W    = DATA_WIDTH - SET_SIZE - 2;
  localparam int NUM_SETS = 1 << SET_SIZE;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] data;
  } block_t;

  // Valid bits live apart from the block array so reset can clear them at once.
  logic [NUM_SETS-1:0]   r_valid;
  block_t                r_block [NUM_SETS];

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-3:0] r_word;     // latched word address
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [SET_SIZE-1:0]   w_cpu_idx;
  logic [TAG_W-1:0]      w_cpu_tag;
  block_t                w_cpu_blk;
  logic                  w_cpu_hit;
  logic                  w_start;
  logic [SET_SIZE-1:0]   w_lat_idx;
  logic [TAG_W-1:0]      w_lat_tag;
  block_t                w_lat_blk;
  logic                  w_lat_hit;
  logic                  w_fill;
  logic                  w_merge;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_lane_wdata;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_cpu_idx = cpu_addr[SET_SIZE+1:2];
  assign w_cpu_tag = cpu_addr[DATA_WIDTH-1:SET_SIZE+2];
  assign w_cpu_blk = r_block[w_cpu_idx];
  assign w_cpu_hit = r_valid[w_cpu_idx] && (w_cpu_blk.tag == w_cpu_tag);
  // Anything other than a load hit needs a memory transaction.
  assign w_start   = cpu_req && (cpu_we || !w_cpu_hit);

  assign w_lat_idx = r_word[SET_SIZE-1:0];
  assign w_lat_tag = r_word[DATA_WIDTH-3:SET_SIZE];
  assign w_lat_blk = r_block[w_lat_idx];
  assign w_lat_hit = r_valid[w_lat_idx] && (w_lat_blk.tag == w_lat_tag);

  // A reset arriving together with the ack abandons the transaction.
  assign w_fill  = rst && (r_state == RD_MISS) && mem_ack;
  assign w_merge = rst && (r_state == WR_THRU) && mem_ack && w_lat_hit;

  // Store lane steering: byte enables and replicated write data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_be         = 4'b1111;
    w_lane_wdata = cpu_wdata;
    case (cpu_size)
      2'b10: begin
        w_be         = 4'b0001 << cpu_addr[1:0];
        w_lane_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = 4'b0011 << {cpu_addr[1], 1'b0};
        w_lane_wdata = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte merge of the latched store into the resident block.
  always_comb begin
    w_merged = w_lat_blk.data;
    for (int b = 0; b < 4; b++) begin
      if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst)        r_valid <= '0;
    else if (w_fill) r_valid[w_lat_idx] <= 1'b1;
  end

  // Block storage: written on fill or on a write-through hit.
  always_ff @(posedge clk) begin
    // NOTE: the block array is not reset; clearing the valid bits is enough to make its contents unreachable.
    if (w_fill)       r_block[w_lat_idx] <= '{tag: w_lat_tag, data: mem_rdata};
    else if (w_merge) r_block[w_lat_idx] <= '{tag: w_lat_tag, data: w_merged};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Request latches: captured when a transaction starts, held until it ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      r_word  <= cpu_addr[DATA_WIDTH-1:2];
      r_be    <= w_be;
      r_wdata <= w_lane_wdata;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (cpu_req && cpu_we)          w_next_state = WR_THRU;
        else if (cpu_req && !w_cpu_hit) w_next_state = RD_MISS;
      end
      RD_MISS, WR_THRU: if (mem_ack) w_next_state = IDLE;
      default:          w_next_state = IDLE;
    endcase
  end

  // FSM outputs; everything is held at zero while reset is asserted.
  always_comb begin
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (rst) begin
      case (r_state)
        IDLE: begin
          cpu_stall = w_start;
          cpu_rdata = w_cpu_hit ? w_cpu_blk.data : '0;
        end
        RD_MISS: begin
          mem_req   = 1'b1;
          mem_addr  = {r_word, 2'b00};
          mem_be    = 4'b1111;
          cpu_stall = !mem_ack;
          cpu_rdata = mem_ack ? mem_rdata : '0;
        end
        WR_THRU: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {r_word, 2'b00};
          mem_be    = r_be;
          mem_wdata = r_wdata;
          cpu_stall = !mem_ack;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
`timescale 1ns/1ps
// tb_data_cache_ctrl: directed table plus randomized accesses against a
// word-level memory/residency model of the write-through cache.
module tb_data_cache_ctrl;

  logic        clk, rst, cpu_req, cpu_we, cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [1:0]  cpu_size;
  logic [3:0]  mem_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  data_cache_ctrl #(.DATA_WIDTH(32), .SET_SIZE(10)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    int unsigned stalls;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } exp_t;

  typedef struct {
    int unsigned stalls;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
    int unsigned req_errs;
  } obs_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned delay;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];

  // Model: backing memory by word address, and which word each set holds.
  logic [31:0] mem_model [int unsigned];
  int unsigned resident  [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int unsigned wa = addr >> 2;
    if (mem_model.exists(wa)) return mem_model[wa];
    return wa * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Expected behaviour of one access, and update of the model afterwards.
  task automatic predict(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned delay, output exp_t e);
    int unsigned wa  = addr >> 2;
    int unsigned idx = wa % 1024;
    logic [31:0] word;
    e.rdata  = mem_word(addr);
    e.be     = 4'h0;
    e.mwdata = 32'h0;
    e.stalls = delay;
    if (we) begin
      case (size)
        2'b10: begin
          e.be     = 4'(1 << addr[1:0]);
          e.mwdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
        end
        2'b01: begin
          e.be     = 4'(3 << (2 * addr[1]));
          e.mwdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
        end
        default: begin
          e.be     = 4'hF;
          e.mwdata = wdata;
        end
      endcase
      word = mem_word(addr);
      for (int b = 0; b < 4; b++) if (e.be[b]) word[8*b +: 8] = e.mwdata[8*b +: 8];
      mem_model[wa] = word;
    end else if (resident.exists(idx) && resident[idx] == wa) begin
      e.stalls = 0;
    end else begin
      resident[idx] = wa;
    end
  endtask

  // Drives one CPU access starting at the next edge and plays the memory,
  // acking in cycle `delay`. Ends on the falling edge of the last cycle.
  task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned delay, output obs_t o);
    o.stalls = 0; o.rdata = 0; o.maddr = 0; o.be = 0; o.mwdata = 0; o.mwe = 0; o.req_errs = 0;
    @(posedge clk); #1;
    mem_ack = 1'b0; cpu_req = 1'b1; cpu_we = we; cpu_size = size;
    cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    if (mem_req) o.req_errs++;
    if (!cpu_stall) begin
      o.rdata = cpu_rdata;
    end else begin
      o.stalls = 1;
      for (int cyc = 1; cyc <= int'(delay); cyc++) begin
        @(posedge clk); #1;
        if (cyc == int'(delay)) begin
          mem_ack = 1'b1; mem_rdata = mem_word(addr);
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        if (!mem_req) o.req_errs++;
        if (cyc == 1) begin
          o.maddr = mem_addr; o.be = mem_be; o.mwdata = mem_wdata; o.mwe = mem_we;
        end else if (o.maddr !== mem_addr || o.be !== mem_be ||
                     o.mwdata !== mem_wdata || o.mwe !== mem_we) begin
          o.req_errs++;
        end
        if (cyc == int'(delay)) begin
          o.rdata = cpu_rdata;
          if (cpu_stall) o.req_errs++;
        end else if (!cpu_stall) begin
          o.req_errs++;
        end else begin
          o.stalls++;
        end
      end
    end
  endtask

  task automatic compare(input string tag, input logic we, input logic [31:0] addr,
                         input exp_t e, input obs_t o);
    check({tag, " stalls"}, o.stalls, e.stalls);
    check({tag, " req_protocol_errs"}, o.req_errs, 0);
    if (!we) check({tag, " rdata"}, o.rdata, e.rdata);
    if (e.stalls > 0) begin
      check({tag, " mem_addr"}, o.maddr, {addr[31:2], 2'b00});
      check({tag, " mem_we"}, {31'd0, o.mwe}, {31'd0, we});
    end
    if (we) begin
      check({tag, " mem_be"}, {28'd0, o.be}, {28'd0, e.be});
      check({tag, " mem_wdata"}, o.mwdata, e.mwdata);
    end
  endtask

  task automatic run_model(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int unsigned delay);
    exp_t e;
    obs_t o;
    predict(we, size, addr, wdata, delay, e);
    access(we, size, addr, wdata, delay, o);
    compare(tag, we, addr, e, o);
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input int unsigned delay, input int unsigned stalls,
                     input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] mwdata);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.delay = delay;
    v.e.stalls = stalls; v.e.rdata = rdata; v.e.be = be; v.e.mwdata = mwdata;
    tbl.push_back(v);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " cpu_stall"}, {31'd0, cpu_stall}, 0);
    check({tag, " mem_req"}, {31'd0, mem_req}, 0);
    check({tag, " mem_we"}, {31'd0, mem_we}, 0);
    check({tag, " mem_be"}, {28'd0, mem_be}, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " cpu_rdata"}, cpu_rdata, 0);
  endtask

  initial begin
    exp_t e_unused;
    obs_t o;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 0; cpu_size = 2'b00;
    cpu_wdata = 0; mem_rdata = 0; mem_ack = 1'b0;
    mem_model[32'h40 >> 2]   = 32'hDEAD_BEEF;
    mem_model[32'h1040 >> 2] = 32'hCAFE_F00D;
    mem_model[32'h2000 >> 2] = 32'h1122_3344;

    // Reset with a store pending and an ack present: all outputs quiet.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1234; cpu_wdata = 32'hFFFF_FFFF; mem_ack = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    // A stray ack in IDLE must not start anything.
    @(posedge clk); #1; rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("idle_ack cpu_stall", {31'd0, cpu_stall}, 0);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack mem_req", {31'd0, mem_req}, 0);

    //  we   size    addr           wdata          dly stl rdata          be       mwdata
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         3,  3,  32'hDEAD_BEEF, 4'h0,    32'h0);
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         3,  0,  32'hDEAD_BEEF, 4'h0,    32'h0);
    add(1'b0, 2'b00, 32'h0000_1040, 32'h0,         2,  2,  32'hCAFE_F00D, 4'h0,    32'h0);
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         1,  1,  32'hDEAD_BEEF, 4'h0,    32'h0);
    add(1'b1, 2'b10, 32'h0000_0041, 32'h0000_00AB, 2,  2,  32'h0,         4'b0010, 32'hABAB_ABAB);
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         2,  0,  32'hDEAD_ABEF, 4'h0,    32'h0);
    add(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 1,  1,  32'h0,         4'b1100, 32'h1234_1234);
    add(1'b0, 2'b00, 32'h0000_2002, 32'h0,         2,  2,  32'h1234_3344, 4'h0,    32'h0);
    add(1'b1, 2'b11, 32'h0000_1043, 32'h0BAD_F00D, 1,  1,  32'h0,         4'b1111, 32'h0BAD_F00D);
    add(1'b0, 2'b00, 32'h0000_1040, 32'h0,         1,  1,  32'h0BAD_F00D, 4'h0,    32'h0);
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         1,  1,  32'hDEAD_ABEF, 4'h0,    32'h0);
    add(1'b1, 2'b00, 32'h0000_0042, 32'h5566_7788, 2,  2,  32'h0,         4'b1111, 32'h5566_7788);
    add(1'b0, 2'b00, 32'h0000_0040, 32'h0,         4,  0,  32'h5566_7788, 4'h0,    32'h0);

    foreach (tbl[i]) begin
      predict(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].delay, e_unused);
      access(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].delay, o);
      compare($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].e, o);
    end

    // Reset in the middle of a read miss abandons it.
    @(posedge clk); #1;
    mem_ack = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h3000;
    @(negedge clk);
    check("rst_miss c0 cpu_stall", {31'd0, cpu_stall}, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_miss c1 mem_req", {31'd0, mem_req}, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_miss during");
    @(posedge clk); #1; rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("rst_miss after mem_req", {31'd0, mem_req}, 0);
    check("rst_miss after cpu_stall", {31'd0, cpu_stall}, 0);
    resident.delete();
    run_model("post_rst 3000", 1'b0, 2'b00, 32'h3000, 32'h0, 2);
    run_model("post_rst 0040", 1'b0, 2'b00, 32'h0040, 32'h0, 1);
    run_model("post_rst 3000 hit", 1'b0, 2'b00, 32'h3000, 32'h0, 2);

    // Minimum-latency miss followed immediately by a hit.
    run_model("b2b miss", 1'b0, 2'b00, 32'h5004, 32'h0, 1);
    run_model("b2b hit",  1'b0, 2'b00, 32'h5004, 32'h0, 3);

    // Random traffic over a few tags and sets so hits, conflicts and merges occur.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic        we;
      a  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      run_model($sformatf("rnd%0d", i), we, 2'($urandom_range(0, 3)), a, $urandom,
                $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1; cpu_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
      end
    end

    @(posedge clk); #1; cpu_req = 1'b0; mem_ack = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
